// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage data-memory access sequencer (req/gnt/rvalid) with pipeline stall.
// Optional watchdog is built in when MEM_TIMEOUT_EN is defined.
module mem_access_ctrl #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memReadM,
  input  logic              memWriteM,
  input  logic              flushM,
  input  logic [ADDR_W-1:0] ALUResultM,
  input  logic [DATA_W-1:0] writeDataM,
  input  logic              memGnt,
  input  logic              memRValid,
  input  logic [DATA_W-1:0] memRData,
  output logic              memReq,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWData,
  output logic              stallM,
  output logic              bubbleW,
  output logic [DATA_W-1:0] RDM,
  output logic              memErr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_DROP
  } state_t;

  state_t state;
  logic   access;
  logic   busy;
  logic   timeout;
  logic   tmo_fire;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("mem_access_ctrl: TIMEOUT_CYCLES must be nonzero");
  end

  assign access  = (memReadM | memWriteM) & ~flushM;
  assign busy    = (state == S_REQ) | (state == S_WAIT) | (state == S_DROP);
  assign stallM  = ((state == S_IDLE) & access) | busy;
  assign bubbleW = stallM;

  // Watchdog only acts when no handshake event resolves the state this cycle.
  assign tmo_fire = timeout & (((state == S_REQ)  & ~memGnt    & ~flushM) |
                               ((state == S_WAIT) & ~memRValid & ~flushM) |
                               ((state == S_DROP) & ~memRValid));

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_LOG = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CNT_W   = (CNT_LOG > 8) ? CNT_LOG : 8;

  logic [CNT_W-1:0] cnt;
  logic             err;

  assign timeout = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign memErr  = err;

  // Counter is cleared in IDLE, so it restarts on every entry to REQ.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      cnt <= busy ? cnt + CNT_W'(1) : '0;
      err <= tmo_fire;
    end
  end
`else
  assign timeout = 1'b0;
  assign memErr  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      memReq   <= 1'b0;
      memWe    <= 1'b0;
      memAddr  <= '0;
      memWData <= '0;
      RDM      <= '0;
    end else if (tmo_fire) begin
      memReq <= 1'b0;
      RDM    <= '0;
      state  <= (state == S_DROP) ? S_IDLE : S_DONE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (access) begin
            memAddr  <= ALUResultM;
            memWData <= writeDataM;
            memWe    <= memWriteM;
            memReq   <= 1'b1;
            state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (memGnt) begin
            memReq <= 1'b0;
            state  <= flushM ? S_DROP : S_WAIT;
          end else if (flushM) begin
            memReq <= 1'b0;
            state  <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (memRValid) begin
            if (!memWe) begin
              RDM <= memRData;
            end
            state <= S_DONE;
          end else if (flushM) begin
            state <= S_DROP;
          end
        end
        // Granted transaction was squashed: swallow its response.
        S_DROP: begin
          if (memRValid) begin
            state <= S_IDLE;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl; the timeout scenario runs when MEM_TIMEOUT_EN is defined.
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst;
  logic        memReadM;
  logic        memWriteM;
  logic        flushM;
  logic [31:0] ALUResultM;
  logic [31:0] writeDataM;
  logic        memGnt;
  logic        memRValid;
  logic [31:0] memRData;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [31:0] memWData;
  logic        stallM;
  logic        bubbleW;
  logic [31:0] RDM;
  logic        memErr;

  int n_checks = 0;
  int n_pass   = 0;

  mem_access_ctrl #(
    .ADDR_W        (32),
    .DATA_W        (32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .memReadM  (memReadM),
    .memWriteM (memWriteM),
    .flushM    (flushM),
    .ALUResultM(ALUResultM),
    .writeDataM(writeDataM),
    .memGnt    (memGnt),
    .memRValid (memRValid),
    .memRData  (memRData),
    .memReq    (memReq),
    .memWe     (memWe),
    .memAddr   (memAddr),
    .memWData  (memWData),
    .stallM    (stallM),
    .bubbleW   (bubbleW),
    .RDM       (RDM),
    .memErr    (memErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance to just after the next rising edge; caller then drives inputs and waits #1 to sample.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Minimum-latency load: access cycle 0, grant cycle 1, response cycle 2, DONE cycle 3.
  task automatic load_txn(input string tag, input logic [31:0] addr, input logic [31:0] data);
    next();
    memReadM = 1'b1; memWriteM = 1'b0; ALUResultM = addr; writeDataM = 32'h77;
    #1;
    check({tag, "_c0_stall"}, 32'(stallM), 32'd1);
    check({tag, "_c0_req"},   32'(memReq), 32'd0);
    next();
    memGnt = 1'b1;
    #1;
    check({tag, "_c1_req"},   32'(memReq), 32'd1);
    check({tag, "_c1_addr"},  memAddr,     addr);
    check({tag, "_c1_we"},    32'(memWe),  32'd0);
    check({tag, "_c1_stall"}, 32'(stallM), 32'd1);
    next();
    memGnt = 1'b0; memRValid = 1'b1; memRData = data;
    #1;
    check({tag, "_c2_req"},   32'(memReq), 32'd0);
    check({tag, "_c2_stall"}, 32'(stallM), 32'd1);
    next();
    memRValid = 1'b0; memRData = 32'h0;
    #1;
    check({tag, "_done_stall"},  32'(stallM),  32'd0);
    check({tag, "_done_bubble"}, 32'(bubbleW), 32'd0);
    check({tag, "_done_rdm"},    RDM,          data);
    check({tag, "_done_err"},    32'(memErr),  32'd0);
  endtask

  initial begin
    rst = 1'b0; memReadM = 1'b0; memWriteM = 1'b0; flushM = 1'b0;
    ALUResultM = '0; writeDataM = '0; memGnt = 1'b0; memRValid = 1'b0; memRData = '0;
    repeat (3) next();
    rst = 1'b1;
    #1;
    check("rst_req",   32'(memReq),  32'd0);
    check("rst_we",    32'(memWe),   32'd0);
    check("rst_addr",  memAddr,      32'd0);
    check("rst_wdata", memWData,     32'd0);
    check("rst_rdm",   RDM,          32'd0);
    check("rst_err",   32'(memErr),  32'd0);
    check("rst_stall", 32'(stallM),  32'd0);

    // Basic load.
    load_txn("ld1", 32'h40, 32'hDEADBEEF);
    next();
    memReadM = 1'b0;
    #1;
    check("ld1_idle_stall", 32'(stallM), 32'd0);
    check("ld1_idle_req",   32'(memReq), 32'd0);

    // Store with grant delayed by 4 cycles.
    next();
    memWriteM = 1'b1; ALUResultM = 32'h100; writeDataM = 32'h55;
    #1;
    check("st_c0_stall", 32'(stallM), 32'd1);
    for (int i = 0; i < 4; i++) begin
      next();
      #1;
      check("st_hold_req",   32'(memReq), 32'd1);
      check("st_hold_we",    32'(memWe),  32'd1);
      check("st_hold_addr",  memAddr,     32'h100);
      check("st_hold_wdata", memWData,    32'h55);
      check("st_hold_stall", 32'(stallM), 32'd1);
    end
    next();
    memGnt = 1'b1;
    #1;
    check("st_gnt_req", 32'(memReq), 32'd1);
    next();
    memGnt = 1'b0; memRValid = 1'b1; memRData = 32'h12345678;
    #1;
    check("st_wait_req",   32'(memReq), 32'd0);
    check("st_wait_stall", 32'(stallM), 32'd1);
    next();
    memRValid = 1'b0;
    #1;
    check("st_done_stall", 32'(stallM), 32'd0);
    check("st_done_rdm",   RDM,         32'hDEADBEEF);
    next();
    memWriteM = 1'b0;

    // Flush while in REQ before grant: abort, no DONE.
    next();
    memReadM = 1'b1; ALUResultM = 32'h200;
    #1;
    next();
    flushM = 1'b1;
    #1;
    check("flreq_req",   32'(memReq), 32'd1);
    check("flreq_stall", 32'(stallM), 32'd1);
    next();
    flushM = 1'b0; memReadM = 1'b0;
    #1;
    check("flreq_abort_req",   32'(memReq), 32'd0);
    check("flreq_abort_stall", 32'(stallM), 32'd0);
    next();
    #1;
    check("flreq_idle_stall", 32'(stallM), 32'd0);
    check("flreq_rdm",        RDM,         32'hDEADBEEF);

    // Flush while in WAIT: DROP until response, then IDLE with RDM untouched.
    next();
    memReadM = 1'b1; ALUResultM = 32'h300;
    #1;
    next();
    memGnt = 1'b1;
    #1;
    next();
    memGnt = 1'b0; flushM = 1'b1;
    #1;
    check("flwait_stall", 32'(stallM), 32'd1);
    next();
    flushM = 1'b0; memReadM = 1'b0;
    #1;
    check("drop_stall0", 32'(stallM), 32'd1);
    next();
    #1;
    check("drop_stall1", 32'(stallM), 32'd1);
    memRValid = 1'b1; memRData = 32'hCAFEF00D;
    next();
    memRValid = 1'b0;
    #1;
    check("drop_exit_stall", 32'(stallM), 32'd0);
    check("drop_exit_rdm",   RDM,         32'hDEADBEEF);

    // Reset during WAIT, then a stray response after release.
    next();
    memReadM = 1'b1; ALUResultM = 32'h400;
    #1;
    next();
    memGnt = 1'b1;
    #1;
    next();
    memGnt = 1'b0; rst = 1'b0;
    #1;
    check("rstw_stall_pre", 32'(stallM), 32'd1);
    next();
    rst = 1'b1; memReadM = 1'b0;
    #1;
    check("rstw_req",   32'(memReq), 32'd0);
    check("rstw_addr",  memAddr,     32'd0);
    check("rstw_wdata", memWData,    32'd0);
    check("rstw_rdm",   RDM,         32'd0);
    check("rstw_stall", 32'(stallM), 32'd0);
    next();
    memRValid = 1'b1; memRData = 32'h99999999;
    #1;
    check("rstw_rv_stall", 32'(stallM), 32'd0);
    next();
    memRValid = 1'b0;
    #1;
    check("rstw_after_rdm",   RDM,         32'd0);
    check("rstw_after_stall", 32'(stallM), 32'd0);
    check("rstw_after_req",   32'(memReq), 32'd0);

    // Back-to-back loads: second starts in the cycle after DONE.
    load_txn("b2b1", 32'h500, 32'h11111111);
    load_txn("b2b2", 32'h504, 32'h22222222);
    next();
    memReadM = 1'b0;
    #1;
    check("b2b_idle_stall", 32'(stallM), 32'd0);

`ifdef MEM_TIMEOUT_EN
    begin
      int errs;
      logic done;
      errs = 0;
      done = 1'b0;
      next();
      memWriteM = 1'b1; ALUResultM = 32'h600; writeDataM = 32'hAA;
      #1;
      for (int i = 0; i < 40 && !done; i++) begin
        next();
        #1;
        if (memErr) errs++;
        if (!stallM) done = 1'b1;
      end
      check("tmo_released", 32'(done), 32'd1);
      check("tmo_pulses",   32'(errs), 32'd1);
      check("tmo_rdm",      RDM,       32'd0);
      check("tmo_req",      32'(memReq), 32'd0);
      next();
      memWriteM = 1'b0;
      #1;
      check("tmo_err_clear", 32'(memErr), 32'd0);
      check("tmo_idle",      32'(stallM), 32'd0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
